// File: rtl/maze_mem.sv
// maze_mem: wall and visited-cell storage for the maze solver.
// After reset the wall and visited arrays are cleared one row per cycle.
// The maze is then loaded one row per beat through a valid/ready port.
// In RUN the block serves one-cycle reads and visited-cell marks, and keeps a
// count of distinct visited cells.
// DONE freezes the marks and the count, but reads are still served.
// Optional feature macro: MAZE_MEM_ERR_EN. When it is defined, the block gets a
// sticky err output, and writes to wall cells are suppressed.
module maze_mem #(
  parameter int maze_width = 6
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        load_valid,
  output logic                        load_ready,
  input  logic [(2**maze_width)-1:0]  load_data,
  input  logic [maze_width-1:0]       row,
  input  logic [maze_width-1:0]       col,
  input  logic                        maze_oe,
  input  logic                        maze_we,
  output logic                        maze_in,
  input  logic                        done,
  output logic                        mem_ready,
  output logic [2*maze_width:0]       visited_count
`ifdef MAZE_MEM_ERR_EN
  ,
  output logic                        err
`endif
);

  localparam int N  = 2**maze_width;
  localparam int CW = 2*maze_width + 1;
  localparam logic [CW-1:0]         CELLS = CW'(N*N);
  localparam logic [maze_width-1:0] RMAX  = '1;

  typedef enum logic [1:0] {ST_CLEAR, ST_LOAD, ST_RUN, ST_DONE} state_t;

  state_t                state_q, state_d;
  logic [maze_width-1:0] r_q, r_d;
  logic                  maze_in_q, maze_in_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  logic [N-1:0] wall_q [N];
  logic [N-1:0] vis_q  [N];

  logic clr_en, load_en, mark_en;
  logic serving;
  logic wall_bit, vis_bit;

`ifdef MAZE_MEM_ERR_EN
  logic err_q, err_set;
`endif

  assign wall_bit = wall_q[row][col];
  assign vis_bit  = vis_q[row][col];
  assign serving  = (state_q == ST_RUN) || (state_q == ST_DONE);

  // Next-state, array write enables and handshake outputs
  always_comb begin
    state_d    = state_q;
    r_d        = r_q;
    clr_en     = 1'b0;
    load_en    = 1'b0;
    mark_en    = 1'b0;
    maze_in_d  = maze_in_q;
    cnt_d      = cnt_q;
    load_ready = 1'b0;
    mem_ready  = 1'b0;
`ifdef MAZE_MEM_ERR_EN
    err_set    = 1'b0;
`endif
    case (state_q)
      ST_CLEAR: begin
        clr_en = 1'b1;
        r_d    = r_q + maze_width'(1);
        // r wraps back to 0 here, which is the first row to load
        if (r_q == RMAX) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        load_ready = 1'b1;
        if (load_valid) begin
          load_en = 1'b1;
          r_d     = r_q + maze_width'(1);
          if (r_q == RMAX) state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        mem_ready = 1'b1;
        if (maze_we) begin
`ifdef MAZE_MEM_ERR_EN
          mark_en = !wall_bit;
          err_set = wall_bit;
`else
          mark_en = 1'b1;
`endif
        end
        if (done) state_d = ST_DONE;
      end
      ST_DONE: begin
        mem_ready = 1'b1;
`ifdef MAZE_MEM_ERR_EN
        if (maze_we) err_set = 1'b1;
`endif
      end
      default: state_d = ST_CLEAR;
    endcase

    if (serving && maze_oe) maze_in_d = wall_bit;
    // Only a first visit to a cell is counted, and the count stops at N*N
    if (mark_en && !vis_bit && (cnt_q != CELLS)) cnt_d = cnt_q + CW'(1);
`ifdef MAZE_MEM_ERR_EN
    if (!serving && (maze_oe || maze_we)) err_set = 1'b1;
`endif
  end

  // Control registers are reset asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_CLEAR;
      r_q       <= '0;
      maze_in_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      r_q       <= r_d;
      maze_in_q <= maze_in_d;
      cnt_q     <= cnt_d;
    end
  end

  // The arrays are not reset; the CLEAR pass zeroes them instead
  always_ff @(posedge clk) begin
    if (clr_en) begin
      wall_q[r_q] <= '0;
      vis_q[r_q]  <= '0;
    end
    if (load_en) wall_q[r_q] <= load_data;
    if (mark_en) vis_q[row][col] <= 1'b1;
  end

`ifdef MAZE_MEM_ERR_EN
  // The error flag is sticky until reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       err_q <= 1'b0;
    else if (err_set) err_q <= 1'b1;
  end

  assign err = err_q;
`endif

  assign maze_in       = maze_in_q;
  assign visited_count = cnt_q;

endmodule

// File: tb/tb_maze_mem.sv
module tb_maze_mem;
  localparam int MW = 6;
  localparam int N  = 64;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            load_valid = 1'b0;
  logic            load_ready;
  logic [N-1:0]    load_data = '0;
  logic [MW-1:0]   row = '0;
  logic [MW-1:0]   col = '0;
  logic            maze_oe = 1'b0;
  logic            maze_we = 1'b0;
  logic            maze_in;
  logic            done = 1'b0;
  logic            mem_ready;
  logic [2*MW:0]   visited_count;
`ifdef MAZE_MEM_ERR_EN
  logic            err;
`endif

  always #5 clk = ~clk;

  maze_mem #(.maze_width(MW)) dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .row(row), .col(col), .maze_oe(maze_oe), .maze_we(maze_we),
    .maze_in(maze_in), .done(done), .mem_ready(mem_ready), .visited_count(visited_count)
`ifdef MAZE_MEM_ERR_EN
    , .err(err)
`endif
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model
  logic [N-1:0] m_wall [N];
  logic [N-1:0] m_vis  [N];
  int           m_cnt;
  bit           m_in;
  bit           m_done;
  bit           m_err;

  typedef struct {
    string tag;
    bit    in;
    int    cnt;
    bit    er;
  } exp_t;
  exp_t sb[$];

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_vis[i] = '0;
    m_cnt = 0; m_in = 0; m_done = 0; m_err = 0;
  endtask

  task automatic gen_rows();
    for (int i = 0; i < N; i++) m_wall[i] = {$urandom, $urandom};
    m_wall[5] = '0; m_wall[5][7] = 1'b1;
    m_wall[1] = '0; m_wall[1][10] = 1'b1;
    m_wall[2] = '0;
  endtask

  // One solver cycle: push expectation, apply edge, pop and compare
  task automatic op(input int r, input int c, input bit oe, input bit we, input bit dn,
                    input string tag);
    exp_t e;
    bit   blk;
    blk = 0;
    row = r[MW-1:0]; col = c[MW-1:0];
    maze_oe = oe; maze_we = we; done = dn;
    if (oe) m_in = m_wall[r][c];
    if (we && !m_done) begin
`ifdef MAZE_MEM_ERR_EN
      blk = m_wall[r][c];
      if (blk) m_err = 1;
`endif
      if (!blk && !m_vis[r][c]) begin
        m_vis[r][c] = 1'b1;
        m_cnt++;
      end
    end else if (we && m_done) begin
`ifdef MAZE_MEM_ERR_EN
      m_err = 1;
`endif
    end
    if (dn) m_done = 1;
    e.tag = tag; e.in = m_in; e.cnt = m_cnt; e.er = m_err;
    sb.push_back(e);
    @(posedge clk); #1;
    maze_oe = 0; maze_we = 0; done = 0;
    e = sb.pop_front();
    chk({e.tag, "_in"}, maze_in, e.in);
    chk({e.tag, "_cnt"}, visited_count, e.cnt);
`ifdef MAZE_MEM_ERR_EN
    chk({e.tag, "_err"}, err, e.er);
`endif
  endtask

  task automatic wait_clear();
    int n;
    n = 0;
    while (!load_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("clear_cycles", n, N);
  endtask

  task automatic load_rows(input int nbeats);
    bit tg;
    bit acc;
    int beats;
    int cyc;
    tg = 0; beats = 0; cyc = 0;
    while (beats < nbeats && cyc < 1000) begin
      tg = ~tg;
      load_valid = tg;
      load_data  = m_wall[beats];
      if (beats == N-1 && tg) chk("mem_ready_before_last", mem_ready, 0);
      acc = load_valid && load_ready;
      @(posedge clk); #1;
      cyc++;
      if (acc) beats++;
    end
    load_valid = 0;
    chk("load_beats", beats, nbeats);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_load_ready"}, load_ready, 0);
    chk({tag, "_mem_ready"}, mem_ready, 0);
    chk({tag, "_maze_in"}, maze_in, 0);
    chk({tag, "_count"}, visited_count, 0);
`ifdef MAZE_MEM_ERR_EN
    chk({tag, "_err"}, err, 0);
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    gen_rows();
    model_reset();
    #2;
    check_reset_outputs("rst");
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    wait_clear();
    load_rows(N);
    chk("mem_ready_after_load", mem_ready, 1);
    chk("load_ready_after_load", load_ready, 0);

    // Read latency and hold
    op(5, 7, 1, 0, 0, "rd57");
    op(5, 8, 1, 0, 0, "rd58");
    op(0, 0, 0, 0, 0, "idle");
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        op(r, c, 1, 0, 0, "sweep");

    // Visited counting
    op(1, 1, 0, 1, 0, "we11");
    op(1, 2, 0, 1, 0, "we12");
    op(1, 1, 0, 1, 0, "we11_again");
    op(1, 3, 1, 1, 0, "rdwe13");
    op(1, 10, 1, 1, 0, "we_wall");
    op(3, 3, 0, 1, 0, "we33_legal");
    op(2, 2, 0, 1, 1, "done22");
    op(2, 3, 1, 1, 0, "we_done");
    op(5, 7, 1, 0, 0, "rd_done");

    // Asynchronous reset from DONE while maze_in and count are non-zero
    #2 rst_n = 0;
    #1 check_reset_outputs("async_done");
    sb.delete();
    @(posedge clk); #1 rst_n = 1;
    gen_rows();
    model_reset();
    wait_clear();
`ifdef MAZE_MEM_ERR_EN
    maze_oe = 1;
    @(posedge clk); #1;
    maze_oe = 0;
    chk("err_early_oe", err, 1);
`endif
    load_rows(10);
    #2 rst_n = 0;
    #1 check_reset_outputs("async_load");
    @(posedge clk); #1 rst_n = 1;
    gen_rows();
    model_reset();
    wait_clear();
    load_rows(N);
    chk("reload_mem_ready", mem_ready, 1);
    chk("reload_count", visited_count, 0);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        op(r, c, 1, 0, 0, "sweep2");
    op(1, 1, 0, 1, 0, "we11_reload");
    op(5, 7, 1, 1, 0, "rdwe57_reload");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/maze_mem.md
# maze_mem

Wall and visited-cell storage for the maze solver. It sits directly beside the solver, on the other side of its `row`/`col`/`maze_oe`/`maze_we`/`maze_in` port. After reset it clears its arrays and loads the maze one row per beat through a valid/ready port. It then serves the solver's synchronous reads and visited-cell marks, counts distinct visited cells, and freezes when the solver raises `done`.

## Interface
- `maze_width`, default 6: coordinate width. The maze is N×N with N = 2**maze_width.
- `clk`, input, 1: the single clock. All state changes on the rising edge.
- `rst_n`, input, 1: reset. Asynchronous assert, active-low.
- `load_valid`, input, 1: `load_data` carries the next maze row.
- `load_ready`, output, 1: block accepts a row this cycle.
- `load_data`, input, N: wall bits of one row. Bit c = column c; 1 = wall.
- `row`, `col`, input, maze_width each: cell address from the solver.
- `maze_oe`, input, 1: read request.
- `maze_we`, input, 1: mark-visited request.
- `maze_in`, output, 1: registered wall bit returned to the solver.
- `done`, input, 1: solver has found the exit.
- `mem_ready`, output, 1: maze is loaded and the block is serving the solver.
- `visited_count`, output, 2*maze_width+1: number of distinct visited cells. Saturates at N*N.

## Operation
States:
- **CLEAR**: entered on reset. A row counter r runs 0..N-1, zeroing wall row r and visited row r each cycle. After r = N-1, go to LOAD with r = 0.
- **LOAD**: `load_ready` = 1. A beat is accepted when `load_valid` && `load_ready`: wall row r ← `load_data`, then r increments. After the beat with r = N-1, go to RUN. With no beat, hold.
- **RUN**: `mem_ready` = 1.
  - `maze_oe`: `maze_in` ← wall[row][col] on the next edge.
  - `maze_we`: visited[row][col] ← 1. `visited_count` increments only if the cell was previously 0.
  - `done` = 1: go to DONE.
- **DONE**: `mem_ready` stays 1. Reads are still served. Writes are ignored and the count is frozen. Exit only via reset.

Rules:
- The solver must not assert `maze_oe`/`maze_we` before `mem_ready`. Outside RUN/DONE these requests are ignored.
- Walls are never modified by `maze_we`.
- `maze_oe` and `maze_we` in the same cycle are both performed. The read returns the wall bit, which the write does not affect.
- `maze_in` holds its last value in cycles without `maze_oe`.
- Arithmetic: `visited_count` is unsigned. Increment is suppressed at N*N; there is no wrap.
- `row`/`col` are always in range for width maze_width. No bounds check is needed.

## Timing
- Reset values: `load_ready` = 0, `mem_ready` = 0, `maze_in` = 0, `visited_count` = 0. State = CLEAR, r = 0.
- Reset mid-operation (any state): all of the above apply immediately and asynchronously. Arrays are re-cleared by CLEAR.
- CLEAR lasts exactly N cycles after reset release. `load_ready` rises on the following edge.
- The LOAD→RUN transition is registered. `mem_ready` is 1 in the cycle after the last accepted beat.
- Read latency is 1 cycle: `maze_oe` sampled at edge k → `maze_in` valid after edge k, for use in cycle k+1.
- A write at edge k is visible in `visited_count` after edge k.
- `done` sampled at edge k → DONE from edge k. A `maze_we` in the same cycle as `done` is still performed.

## Configuration
- `MAZE_MEM_ERR_EN` defined:
  - Adds output `err` (1 bit, reset 0, sticky until reset).
  - `err` sets on: `maze_we` to a wall cell (that write is suppressed and not counted); `maze_oe`/`maze_we` before `mem_ready`; `maze_we` in DONE.
- Not defined: no `err` port. Writes to wall cells mark visited and count normally. Other illegal requests are silently ignored.

## Test plan
- **Reset/clear/load (N = 64)**:
  - Release `rst_n`: `load_ready` rises after 64 cycles.
  - Feed 64 rows with `load_valid` toggled every other cycle: exactly 64 beats accepted; `mem_ready` = 1 the cycle after the last beat.
- **Read latency**:
  - Row 5 = 1<<7.
  - `maze_oe` with (5,7) → `maze_in` = 1 next cycle.
  - (5,8) → 0.
  - Idle cycle → `maze_in` holds 0.
- **Visited count**:
  - `maze_we` at (1,1), (1,2), (1,1) → `visited_count` = 1, 2, 2.
  - `maze_oe` and `maze_we` together at (1,3) → count 3; `maze_in` returns the wall bit.
- **Done freeze**: assert `done` together with `maze_we` at (2,2) → count 4. A later `maze_we` at (2,3) → count stays 4; reads still work.
- **Reset mid-LOAD**: pull `rst_n` low after 10 beats → `load_ready` = 0 and `mem_ready` = 0 immediately. After release, CLEAR runs 64 cycles, then the full reload succeeds with count 0.
- **With `MAZE_MEM_ERR_EN`**:
  - `maze_we` on a wall cell → `err` = 1, count unchanged.
  - `err` stays 1 across subsequent legal traffic.
